// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage request/response bundle between the controller (master) and the M-unit (slave).
interface muldiv_sequencer_if
    import muldiv_pkg::*;
    ();
    logic                   Start;
    logic [2:0]             Funct3;
    logic [MULDIV_XLEN-1:0] SrcA;
    logic [MULDIV_XLEN-1:0] SrcB;
    logic                   Flush;
    logic                   Busy;
    logic                   Done;
    logic [MULDIV_XLEN-1:0] Result;

    modport master (
        output Start, Funct3, SrcA, SrcB, Flush,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, Funct3, SrcA, SrcB, Flush,
        output Busy, Done, Result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide, Done 34 cycles after Start.
// Busy stalls the pipeline through RUN and FIX; divide-by-zero and signed overflow finish in one cycle.
module muldiv_sequencer
    import muldiv_pkg::*;
    #(parameter int XLEN = 32)
    (
        input  logic                clk,
        input  logic                reset,
        muldiv_sequencer_if.slave   bus
    );

    muldiv_state_t   state_q;
    logic [5:0]      cnt_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] mcand_q;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;     // {hi, lo}: product, or {remainder, dividend/quotient}
    logic            neg_q;
    logic            neg_r_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    logic            is_div_d, a_signed_d, b_signed_d, a_neg_d, b_neg_d;
    logic [XLEN-1:0] a_mag_d, b_mag_d, special_res_d;
    logic            div_zero_d, div_ovf_d;

    always_comb begin
        is_div_d   = bus.Funct3[2];
        a_signed_d = (bus.Funct3 == F3_MULH) || (bus.Funct3 == F3_MULHSU) ||
                     (bus.Funct3 == F3_DIV)  || (bus.Funct3 == F3_REM);
        b_signed_d = (bus.Funct3 == F3_MULH) || (bus.Funct3 == F3_DIV) || (bus.Funct3 == F3_REM);
        a_neg_d    = a_signed_d & bus.SrcA[XLEN-1];
        b_neg_d    = b_signed_d & bus.SrcB[XLEN-1];
        a_mag_d    = cond_neg(bus.SrcA, a_neg_d);
        b_mag_d    = cond_neg(bus.SrcB, b_neg_d);
        div_zero_d = is_div_d && (bus.SrcB == '0);
        div_ovf_d  = ((bus.Funct3 == F3_DIV) || (bus.Funct3 == F3_REM)) &&
                     (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == '1);
        if (bus.Funct3[1])
            special_res_d = div_ovf_d ? '0 : bus.SrcA;
        else
            special_res_d = div_ovf_d ? {1'b1, {(XLEN-1){1'b0}}} : '1;
    end

    logic [XLEN:0]     mul_sum_d;
    logic [2*XLEN-1:0] mul_next_d;
    logic [XLEN:0]     div_shift_d, div_trial_d;
    logic              div_qbit_d;
    logic [2*XLEN-1:0] div_next_d;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   quo_d, rem_d, fix_res_d;

    always_comb begin
        mul_sum_d   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        mul_next_d  = acc_q[0] ? {mul_sum_d, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        // Remainder stays below the divisor, so the trial difference fits a signed XLEN+1 value.
        div_shift_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial_d = div_shift_d - {1'b0, mcand_q};
        div_qbit_d  = ~div_trial_d[XLEN];
        div_next_d  = {div_qbit_d ? div_trial_d[XLEN-1:0] : div_shift_d[XLEN-1:0],
                       acc_q[XLEN-2:0], div_qbit_d};

        prod_d = cond_neg_wide(acc_q, neg_q);
        quo_d  = cond_neg(acc_q[XLEN-1:0], neg_q);
        rem_d  = cond_neg(acc_q[2*XLEN-1:XLEN], neg_r_q);
        unique case (f3_q)
            F3_MUL:                        fix_res_d = prod_d[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_res_d = prod_d[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_res_d = quo_d;
            default:                       fix_res_d = rem_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.Flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.Start) begin
                        f3_q    <= bus.Funct3;
                        mcand_q <= is_div_d ? b_mag_d : a_mag_d;
                        acc_q   <= {{XLEN{1'b0}}, is_div_d ? a_mag_d : b_mag_d};
                        neg_q   <= a_neg_d ^ b_neg_d;
                        neg_r_q <= a_neg_d;
                        cnt_q   <= 6'(XLEN - 1);
                        if (div_zero_d || div_ovf_d) begin
                            result_q <= special_res_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= f3_q[2] ? div_next_d : mul_next_d;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0)
                        state_q <= FIX;
                end
                FIX: begin
                    result_q <= fix_res_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = result_q;

endmodule
